// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   pc_state_e        : fetch FSM state (init hold, running, halted)
//   DefaultXlen       : default program-counter width in bits
//   DefaultInstBytes  : default sequential increment in bytes
package pc_pkg;

  localparam int unsigned DefaultXlen      = 32;
  localparam int unsigned DefaultInstBytes = 4;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc priority mux with target alignment.
// Ports:
//   pc              in   current fetch address
//   stall           in   hold the pc
//   redir_valid     in   redirect request
//   redir_target    in   redirect destination
//   trap_valid      in   trap request (beats redirect)
//   trap_target     in   trap handler address
//   pc_plus         out  pc + INST_BYTES (wraps modulo 2^XLEN)
//   take_target     out  a trap or redirect is requested this cycle
//   target          out  selected target with low alignment bits cleared
//   target_misalign out  selected target had nonzero low alignment bits
//   run_next        out  next pc in the running state: target > stall > sequential
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN       = DefaultXlen,
  parameter int unsigned INST_BYTES = DefaultInstBytes
) (
  input  logic [XLEN-1:0] pc,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] pc_plus,
  output logic            take_target,
  output logic [XLEN-1:0] target,
  output logic            target_misalign,
  output logic [XLEN-1:0] run_next
);

  localparam logic [XLEN-1:0] LowMask = XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    pc_plus         = pc + XLEN'(INST_BYTES);
    take_target     = trap_valid | redir_valid;
    raw_target      = trap_valid ? trap_target : redir_target;
    target          = raw_target & ~LowMask;
    target_misalign = |(raw_target & LowMask);

    if (take_target) begin
      run_next = target;
    end else if (stall) begin
      run_next = pc;
    end else begin
      run_next = pc_plus;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds RESET_VEC for INIT_CYCLES after reset, then fetches
// sequentially, honouring trap/redirect/stall/halt requests.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   stall         in   hold pc
//   redir_valid   in   branch/jump redirect request
//   redir_target  in   redirect destination
//   trap_valid    in   trap request
//   trap_target   in   trap handler address
//   halt          in   stop fetching
//   pc            out  current fetch address (registered)
//   pc_plus       out  pc + INST_BYTES (combinational)
//   pc_valid      out  pc is a live fetch address
//   misalign      out  last loaded target had nonzero low bits (one cycle)
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = DefaultXlen,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int unsigned     INIT_CYCLES = 1,
  parameter int unsigned     INST_BYTES  = DefaultInstBytes
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            misalign
);

  localparam logic [3:0] InitLast = 4'(INIT_CYCLES - 1);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      init_cnt_q, init_cnt_d;
  logic            mis_q, mis_d;

  // Request captured during the init hold; a trap is never displaced by a redirect.
  logic            pend_valid_q, pend_valid_d;
  logic            pend_trap_q, pend_trap_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            pend_mis_q, pend_mis_d;

  logic            take_target;
  logic [XLEN-1:0] target;
  logic            target_misalign;
  logic [XLEN-1:0] run_next;

  pc_next_sel #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .pc              (pc_q),
    .stall           (stall),
    .redir_valid     (redir_valid),
    .redir_target    (redir_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .pc_plus         (pc_plus),
    .take_target     (take_target),
    .target          (target),
    .target_misalign (target_misalign),
    .run_next        (run_next)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    init_cnt_d    = init_cnt_q;
    mis_d         = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;
    pend_mis_d    = pend_mis_q;

    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 4'd1;
        if (trap_valid || (redir_valid && !pend_trap_q)) begin
          pend_valid_d  = 1'b1;
          pend_trap_d   = pend_trap_q | trap_valid;
          pend_target_d = target;
          pend_mis_d    = target_misalign;
        end
        if (init_cnt_q == InitLast) begin
          state_d    = StRun;
          init_cnt_d = '0;
          if (pend_valid_d) begin
            pc_d  = pend_target_d;
            mis_d = pend_mis_d;
          end
          pend_valid_d = 1'b0;
          pend_trap_d  = 1'b0;
          pend_mis_d   = 1'b0;
        end
      end
      StRun: begin
        if (take_target) begin
          pc_d  = target;
          mis_d = target_misalign;
        end else if (halt) begin
          state_d = StHalt;
        end else begin
          pc_d = run_next;
        end
      end
      StHalt: begin
        // Only a trap or redirect restarts fetch; stall, halt and sequencing are ignored.
        if (take_target) begin
          state_d = StRun;
          pc_d    = target;
          mis_d   = target_misalign;
        end
      end
      default: begin
        state_d = StInit;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StInit;
      pc_q          <= RESET_VEC;
      init_cnt_q    <= '0;
      mis_q         <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= '0;
      pend_mis_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      init_cnt_q    <= init_cnt_d;
      mis_q         <= mis_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
      pend_mis_q    <= pend_mis_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = (state_q == StRun);
  assign misalign = mis_q;

endmodule
